csr_unit: RTL and testbench

- Machine-mode CSR file and trap sequencer for the single-issue RV64 core.
- Sits at the write-back/commit end of the decode-stage control interface. It consumes csr_ctrl, csr_src, inst_ecall and inst_mret from decode, and returns csr_trap to decode.
- Holds all M-mode architectural CSR state.
- Provides CSR read data to the rd write-back path and a PC redirect to fetch on trap entry and on mret.

---
 rtl/csr_unit_pkg.sv | 69 ++++++
 rtl/csr_unit_if.sv | 32 +++
 rtl/csr_unit_counter.sv | 24 ++
 rtl/csr_unit.sv | 143 ++++++++++++++
 tb/tb_csr_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/csr_unit_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, field positions,
// trap causes and csr_ctrl operation encodings.
package csr_unit_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned ZIMM_W     = 5;
  localparam int unsigned CTRL_W     = 3;

  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIE      = 12'h304;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIP      = 12'h344;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET = 12'hB02;
  localparam logic [CSR_ADDR_W-1:0] CSR_MHARTID  = 12'hF14;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LSB  = 11;
  localparam int unsigned MIE_MTIE_BIT     = 7;
  localparam int unsigned MIP_MTIP_BIT     = 7;

  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [XLEN-1:0] MCAUSE_M_TIMER_IRQ = 64'h8000_0000_0000_0007;
  localparam logic [XLEN-1:0] MCAUSE_ECALL_M     = 64'd11;

  // funct3 value decode uses when the instruction is not a CSR access
  localparam logic [CTRL_W-1:0] CSR_CTRL_NONE = 3'b100;

  typedef enum logic [1:0] {
    CSR_FN_NONE = 2'b00,
    CSR_FN_RW   = 2'b01,
    CSR_FN_RS   = 2'b10,
    CSR_FN_RC   = 2'b11
  } csr_fn_e;

  typedef struct packed {
    logic [1:0] mpp;
    logic       mpie;
    logic       mie;
  } mstatus_t;

  function automatic logic [XLEN-1:0] csr_wdata(csr_fn_e fn, logic [XLEN-1:0] old,
                                                logic [XLEN-1:0] op);
    logic [XLEN-1:0] r;
    case (fn)
      CSR_FN_RW: r = op;
      CSR_FN_RS: r = old | op;
      CSR_FN_RC: r = old & ~op;
      default:   r = old;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mstatus_read(mstatus_t s);
    logic [XLEN-1:0] r;
    r = '0;
    r[MSTATUS_MIE_BIT]           = s.mie;
    r[MSTATUS_MPIE_BIT]          = s.mpie;
    r[MSTATUS_MPP_LSB +: 2]      = s.mpp;
    return r;
  endfunction

endpackage

// File: rtl/csr_unit_if.sv
// Decode/commit-side control interface of the CSR unit, plus fetch redirect.
interface csr_unit_if;
  import csr_unit_pkg::*;

  logic                  inst_valid;
  logic [XLEN-1:0]       pc;
  logic [CTRL_W-1:0]     csr_ctrl;
  logic                  csr_src;
  logic [CSR_ADDR_W-1:0] csr_addr;
  logic [XLEN-1:0]       rs1_data;
  logic [ZIMM_W-1:0]     zimm;
  logic                  inst_ecall;
  logic                  inst_mret;
  logic                  mtip;
  logic [XLEN-1:0]       csr_rdata;
  logic                  csr_trap;
  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;

  modport master (
    output inst_valid, pc, csr_ctrl, csr_src, csr_addr, rs1_data, zimm,
           inst_ecall, inst_mret, mtip,
    input  csr_rdata, csr_trap, redirect_valid, redirect_pc
  );

  modport slave (
    input  inst_valid, pc, csr_ctrl, csr_src, csr_addr, rs1_data, zimm,
           inst_ecall, inst_mret, mtip,
    output csr_rdata, csr_trap, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/csr_unit_counter.sv
// Free-running counter with an increment enable; an explicit write wins over
// the increment in the same cycle. Wraps naturally from all-ones to zero.
module csr_counter #(
  parameter int unsigned W = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc_en,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (wr_en) begin
      count <= wr_data;
    end else if (inc_en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap sequencer: holds M-mode state, serves CSR
// reads/writes at commit, and redirects fetch on trap entry and mret.
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter logic [63:0] MTVEC_RESET = 64'h0,
  parameter logic [63:0] MHARTID     = 64'h0
) (
  input  logic       clock,
  input  logic       reset,
  csr_unit_if.slave  bus
);

  mstatus_t        mstatus_q;
  logic            mtie_q;
  logic [XLEN-3:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-3:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;

  logic            irq_pending_c;
  logic            commit_c;
  logic            take_irq_c;
  logic            take_ecall_c;
  logic            take_mret_c;
  logic            trap_enter_c;
  logic            wr_req_c;
  logic            set_clr_c;
  csr_fn_e         fn_c;
  logic [XLEN-1:0] op_c;
  logic [XLEN-1:0] rdata_c;
  logic [XLEN-1:0] wdata_c;
  logic            wr_mcycle_c;
  logic            wr_minstret_c;
  logic            unused_pc_lsb;

  // Old value of the addressed CSR; also the base for set/clear updates.
  always_comb begin
    rdata_c = '0;
    case (bus.csr_addr)
      CSR_MSTATUS:  rdata_c = mstatus_read(mstatus_q);
      CSR_MIE:      rdata_c[MIE_MTIE_BIT] = mtie_q;
      CSR_MTVEC:    rdata_c = {mtvec_q, 2'b00};
      CSR_MSCRATCH: rdata_c = mscratch_q;
      CSR_MEPC:     rdata_c = {mepc_q, 2'b00};
      CSR_MCAUSE:   rdata_c = mcause_q;
      CSR_MIP:      rdata_c[MIP_MTIP_BIT] = bus.mtip;
      CSR_MCYCLE:   rdata_c = mcycle;
      CSR_MINSTRET: rdata_c = minstret;
      CSR_MHARTID:  rdata_c = MHARTID;
      default:      rdata_c = '0;
    endcase
  end

  // Commit-time priority: interrupt, ecall, mret, then the CSR write itself.
  always_comb begin
    irq_pending_c = mstatus_q.mie & mtie_q & bus.mtip;
    commit_c      = bus.inst_valid & ~reset;
    take_irq_c    = commit_c & irq_pending_c;
    take_ecall_c  = commit_c & ~irq_pending_c & bus.inst_ecall;
    take_mret_c   = commit_c & ~irq_pending_c & ~bus.inst_ecall & bus.inst_mret;
    trap_enter_c  = take_irq_c | take_ecall_c;

    fn_c      = csr_fn_e'(bus.csr_ctrl[1:0]);
    op_c      = bus.csr_src ? XLEN'(bus.zimm) : bus.rs1_data;
    set_clr_c = (fn_c == CSR_FN_RS) || (fn_c == CSR_FN_RC);
    wdata_c   = csr_wdata(fn_c, rdata_c, op_c);

    wr_req_c = commit_c & ~trap_enter_c & ~take_mret_c
             & (bus.csr_ctrl != CSR_CTRL_NONE)
             & (fn_c != CSR_FN_NONE)
             & ~(set_clr_c & (op_c == '0));

    wr_mcycle_c   = wr_req_c & (bus.csr_addr == CSR_MCYCLE);
    wr_minstret_c = wr_req_c & (bus.csr_addr == CSR_MINSTRET);
  end

  assign bus.csr_rdata      = rdata_c;
  assign bus.csr_trap       = irq_pending_c;
  assign bus.redirect_valid = trap_enter_c | take_mret_c;
  assign bus.redirect_pc    = trap_enter_c ? {mtvec_q, 2'b00} :
                              take_mret_c  ? {mepc_q, 2'b00}  : '0;

  // mepc is word-aligned, so the low PC bits are never stored.
  assign unused_pc_lsb = ^bus.pc[1:0];

  // Architectural CSR state; MPP only ever holds M once it is written or trapped into.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mstatus_q  <= '0;
      mtie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET[XLEN-1:2];
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (trap_enter_c) begin
      mepc_q         <= bus.pc[XLEN-1:2];
      mcause_q       <= take_irq_c ? MCAUSE_M_TIMER_IRQ : MCAUSE_ECALL_M;
      mstatus_q.mpie <= mstatus_q.mie;
      mstatus_q.mie  <= 1'b0;
      mstatus_q.mpp  <= PRIV_M;
    end else if (take_mret_c) begin
      mstatus_q.mie  <= mstatus_q.mpie;
      mstatus_q.mpie <= 1'b1;
    end else if (wr_req_c) begin
      case (bus.csr_addr)
        CSR_MSTATUS: begin
          mstatus_q.mie  <= wdata_c[MSTATUS_MIE_BIT];
          mstatus_q.mpie <= wdata_c[MSTATUS_MPIE_BIT];
          mstatus_q.mpp  <= PRIV_M;
        end
        CSR_MIE:      mtie_q     <= wdata_c[MIE_MTIE_BIT];
        CSR_MTVEC:    mtvec_q    <= wdata_c[XLEN-1:2];
        CSR_MSCRATCH: mscratch_q <= wdata_c;
        CSR_MEPC:     mepc_q     <= wdata_c[XLEN-1:2];
        CSR_MCAUSE:   mcause_q   <= wdata_c;
        default: ;
      endcase
    end
  end

  csr_counter #(.W(XLEN)) u_mcycle (
    .clock   (clock),
    .reset   (reset),
    .inc_en  (1'b1),
    .wr_en   (wr_mcycle_c),
    .wr_data (wdata_c),
    .count   (mcycle)
  );

  // An interrupted instruction does not retire.
  csr_counter #(.W(XLEN)) u_minstret (
    .clock   (clock),
    .reset   (reset),
    .inc_en  (commit_c & ~take_irq_c),
    .wr_en   (wr_minstret_c),
    .wr_data (wdata_c),
    .count   (minstret)
  );

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: directed commit-stream vectors push expected
// outputs; a negedge monitor pops and compares them.
module tb_csr_unit;
  import csr_unit_pkg::*;

  localparam logic [63:0] MTVEC_RST = 64'h0000_0000_8000_0000;
  localparam logic [63:0] HART_ID   = 64'd5;
  localparam int K_RDATA = 0;
  localparam int K_TRAP  = 1;
  localparam int K_RV    = 2;
  localparam int K_RPC   = 3;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M_IE = 64'h88;

  logic clock;
  logic reset;
  logic tip_lvl;

  csr_unit_if bus();

  csr_unit #(.MTVEC_RESET(MTVEC_RST), .MHARTID(HART_ID)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          kind;
    string       name;
    logic [63:0] exp;
    logic [63:0] mask;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(negedge clock) begin
    exp_t        e;
    logic [63:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RDATA: act = bus.csr_rdata;
        K_TRAP:  act = 64'(bus.csr_trap);
        K_RV:    act = 64'(bus.redirect_valid);
        default: act = bus.redirect_pc;
      endcase
      n_cmp++;
      if ((act & e.mask) !== (e.exp & e.mask)) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h (mask %h)", e.name, act, e.exp, e.mask);
      end
    end
  end

  task automatic chkm(input int kind, input string nm, input logic [63:0] e,
                      input logic [63:0] m);
    exp_t x;
    x.kind = kind; x.name = nm; x.exp = e; x.mask = m;
    sb.push_back(x);
  endtask

  task automatic chk(input int kind, input string nm, input logic [63:0] e);
    chkm(kind, nm, e, ALL1);
  endtask

  task automatic drive(input logic v, input logic [2:0] ctrl, input logic [11:0] addr,
                       input logic [63:0] rs1, input logic [4:0] zi, input logic ec,
                       input logic mr, input logic [63:0] pc_v);
    @(posedge clock);
    #1;
    bus.inst_valid = v;
    bus.csr_ctrl   = ctrl;
    bus.csr_src    = ctrl[2];
    bus.csr_addr   = addr;
    bus.rs1_data   = rs1;
    bus.zimm       = zi;
    bus.inst_ecall = ec;
    bus.inst_mret  = mr;
    bus.pc         = pc_v;
    bus.mtip       = tip_lvl;
  endtask

  task automatic rd(input logic [11:0] a);
    drive(1'b0, 3'b010, a, 64'h0, 5'h0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic csr(input logic [2:0] ctrl, input logic [11:0] a,
                     input logic [63:0] rs1, input logic [4:0] zi);
    drive(1'b1, ctrl, a, rs1, zi, 1'b0, 1'b0, 64'h0000_0000_8000_0400);
  endtask

  task automatic sys(input logic ec, input logic mr, input logic [63:0] pc_v);
    drive(1'b1, CSR_CTRL_NONE, CSR_MSCRATCH, 64'h0, 5'h0, ec, mr, pc_v);
  endtask

  initial begin
    reset = 1'b1;
    tip_lvl = 1'b0;
    bus.inst_valid = 1'b0; bus.csr_ctrl = CSR_CTRL_NONE; bus.csr_src = 1'b0;
    bus.csr_addr = '0; bus.rs1_data = '0; bus.zimm = '0; bus.inst_ecall = 1'b0;
    bus.inst_mret = 1'b0; bus.mtip = 1'b0; bus.pc = '0;

    // mret during reset must not redirect
    drive(1'b1, CSR_CTRL_NONE, CSR_MTVEC, 64'h0, 5'h0, 1'b0, 1'b1, 64'h1234);
    chk(K_RDATA, "rst_mtvec", MTVEC_RST);
    chk(K_RV, "rst_rv", 64'h0);
    chk(K_RPC, "rst_rpc", 64'h0);
    chk(K_TRAP, "rst_trap", 64'h0);
    rd(CSR_MSTATUS);
    reset = 1'b0;
    chk(K_RDATA, "rst_mstatus", 64'h0);
    rd(CSR_MCYCLE);       chk(K_RDATA, "mcycle_first", 64'd1);
    rd(CSR_MHARTID);      chk(K_RDATA, "mhartid", HART_ID);

    csr(3'b001, CSR_MSCRATCH, 64'hDEAD_BEEF, 5'h0);
    chk(K_RDATA, "csrrw_old", 64'h0);
    chk(K_RV, "csrrw_rv", 64'h0);
    csr(3'b110, CSR_MSCRATCH, 64'h0, 5'h10);
    chk(K_RDATA, "csrrsi_old", 64'hDEAD_BEEF);
    rd(CSR_MSCRATCH);     chk(K_RDATA, "mscratch_final", 64'hDEAD_BEFF);
    rd(CSR_MINSTRET);     chk(K_RDATA, "minstret_2", 64'd2);

    csr(3'b001, CSR_MTVEC, 64'h8000_0103, 5'h0);
    chk(K_RDATA, "mtvec_old", MTVEC_RST);
    rd(CSR_MTVEC);        chk(K_RDATA, "mtvec_aligned", 64'h8000_0100);
    csr(3'b110, CSR_MSTATUS, 64'h0, 5'h8);
    chk(K_RDATA, "mstatus_pre_mie", 64'h0);

    sys(1'b1, 1'b0, 64'h8000_0040);
    chk(K_RV, "ecall_rv", 64'h1);
    chk(K_RPC, "ecall_rpc", 64'h8000_0100);
    chk(K_TRAP, "ecall_trap", 64'h0);
    rd(CSR_MEPC);         chk(K_RDATA, "ecall_mepc", 64'h8000_0040);
    rd(CSR_MCAUSE);       chk(K_RDATA, "ecall_mcause", 64'd11);
    rd(CSR_MSTATUS);      chkm(K_RDATA, "ecall_mstatus", 64'h80, M_IE);
    rd(CSR_MINSTRET);     chk(K_RDATA, "ecall_minstret", 64'd5);

    sys(1'b0, 1'b1, 64'h8000_0100);
    chk(K_RV, "mret1_rv", 64'h1);
    chk(K_RPC, "mret1_rpc", 64'h8000_0040);
    rd(CSR_MSTATUS);      chkm(K_RDATA, "mret1_mstatus", 64'h88, M_IE);
    csr(3'b010, CSR_MIE, 64'h80, 5'h0);
    chk(K_RDATA, "mie_old", 64'h0);

    // timer interrupt alongside a csrrw: write suppressed, no retire
    tip_lvl = 1'b1;
    drive(1'b1, 3'b001, CSR_MSCRATCH, 64'h1234, 5'h0, 1'b0, 1'b0, 64'h8000_0200);
    chk(K_TRAP, "irq_trap", 64'h1);
    chk(K_RV, "irq_rv", 64'h1);
    chk(K_RPC, "irq_rpc", 64'h8000_0100);
    chk(K_RDATA, "irq_rdata", 64'hDEAD_BEFF);
    rd(CSR_MSCRATCH);
    chk(K_RDATA, "irq_mscratch", 64'hDEAD_BEFF);
    chk(K_TRAP, "irq_masked", 64'h0);
    rd(CSR_MIP);          chk(K_RDATA, "mip_mtip", 64'h80);
    tip_lvl = 1'b0;
    rd(CSR_MCAUSE);       chk(K_RDATA, "irq_mcause", 64'h8000_0000_0000_0007);
    rd(CSR_MEPC);         chk(K_RDATA, "irq_mepc", 64'h8000_0200);
    rd(CSR_MINSTRET);     chk(K_RDATA, "irq_minstret", 64'd7);
    rd(CSR_MSTATUS);      chkm(K_RDATA, "irq_mstatus", 64'h80, M_IE);

    sys(1'b0, 1'b1, 64'h8000_0100);
    chk(K_RV, "mret2_rv", 64'h1);
    chk(K_RPC, "mret2_rpc", 64'h8000_0200);
    rd(CSR_MSTATUS);      chkm(K_RDATA, "mret2_mstatus", 64'h88, M_IE);

    // pending interrupt with no committing instruction: no redirect, no update
    tip_lvl = 1'b1;
    rd(CSR_MEPC);
    chk(K_TRAP, "idle_trap", 64'h1);
    chk(K_RV, "idle_rv", 64'h0);
    chk(K_RDATA, "idle_mepc", 64'h8000_0200);
    tip_lvl = 1'b0;
    rd(CSR_MCAUSE);
    chk(K_RDATA, "idle_mcause", 64'h8000_0000_0000_0007);
    chk(K_TRAP, "tip_low_trap", 64'h0);

    csr(3'b001, CSR_MCYCLE, ALL1, 5'h0);
    rd(CSR_MCYCLE);       chk(K_RDATA, "mcycle_ones", ALL1);
    rd(CSR_MCYCLE);       chk(K_RDATA, "mcycle_wrap", 64'h0);

    csr(3'b111, CSR_MIE, 64'h0, 5'h0);
    chk(K_RDATA, "csrrci0_old", 64'h80);
    rd(CSR_MIE);          chk(K_RDATA, "csrrci0_mie", 64'h80);
    csr(3'b001, CSR_MIE, ALL1, 5'h0);
    rd(CSR_MIE);          chk(K_RDATA, "mie_wmask", 64'h80);
    csr(3'b011, CSR_MIE, 64'h80, 5'h0);
    chk(K_RDATA, "csrrc_old", 64'h80);
    rd(CSR_MIE);          chk(K_RDATA, "csrrc_mie", 64'h0);

    csr(3'b001, CSR_MINSTRET, 64'd100, 5'h0);
    rd(CSR_MINSTRET);     chk(K_RDATA, "minstret_wr", 64'd100);
    csr(3'b001, CSR_MEPC, 64'h1237, 5'h0);
    rd(CSR_MEPC);         chk(K_RDATA, "mepc_align", 64'h1234);
    csr(3'b001, 12'h7C0, 64'hFF, 5'h0);
    chk(K_RDATA, "unimpl_old", 64'h0);
    rd(12'h7C0);          chk(K_RDATA, "unimpl_rd", 64'h0);
    csr(3'b001, CSR_MHARTID, 64'h0, 5'h0);
    rd(CSR_MHARTID);      chk(K_RDATA, "mhartid_ro", HART_ID);

    // reset asserted mid-operation kills the ecall redirect and all state
    sys(1'b1, 1'b0, 64'h8000_0300);
    reset = 1'b1;
    chk(K_RV, "midrst_rv", 64'h0);
    chk(K_RPC, "midrst_rpc", 64'h0);
    rd(CSR_MSCRATCH);     chk(K_RDATA, "midrst_mscratch", 64'h0);
    rd(CSR_MTVEC);        chk(K_RDATA, "midrst_mtvec", MTVEC_RST);
    rd(CSR_MEPC);         chk(K_RDATA, "midrst_mepc", 64'h0);
    reset = 1'b0;

    rd(CSR_MSTATUS);
    repeat (3) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
